// File: rtl/loop_filter_pkg.sv
// Shared widths, types and the saturating clamp used by the PLL loop filter.
package loop_filter_pkg;

    localparam int DEFAULT_PHASE_W = 16;
    localparam int DEFAULT_OUT_W   = 16;
    localparam int SAT_W           = DEFAULT_OUT_W + 2;

    typedef logic signed [DEFAULT_PHASE_W-1:0] phase_t;
    typedef logic signed [DEFAULT_OUT_W-1:0]   freq_t;

    typedef struct packed {
        logic  sat;
        freq_t value;
    } sat_t;

    // Clamps a two-bit-headroom sum into a signed range of the given width and flags clipping.
    function automatic sat_t sat_signed(input logic signed [SAT_W-1:0] value, input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi      = SAT_W'((64'sd1 <<< (width - 1)) - 64'sd1);
        lo      = ~hi;
        r.sat   = 1'b0;
        r.value = freq_t'(value);
        if (value > hi) begin
            r.sat   = 1'b1;
            r.value = freq_t'(hi);
        end else if (value < lo) begin
            r.sat   = 1'b1;
            r.value = freq_t'(lo);
        end
        return r;
    endfunction

endpackage

// File: rtl/loop_filter_if.sv
// Sample/tuning-word bus between the phase detector, the loop filter and the NCO.
interface loop_filter_if #(
    parameter int PHASE_W = loop_filter_pkg::DEFAULT_PHASE_W,
    parameter int OUT_W   = loop_filter_pkg::DEFAULT_OUT_W
);

    logic                      tick;
    logic                      clear_i;
    logic signed [PHASE_W-1:0] phase_i;
    logic signed [OUT_W-1:0]   freq_o;
    logic                      valid_o;
    logic                      sat_o;

    modport master (
        output tick, clear_i, phase_i,
        input  freq_o, valid_o, sat_o
    );

    modport slave (
        input  tick, clear_i, phase_i,
        output freq_o, valid_o, sat_o
    );

endinterface

// File: rtl/loop_filter_boxcar_decimator.sv
// Box-car average of 2**LOG2_AVG tick-rate samples, emitting one floor-rounded mean per block.
module boxcar_decimator #(
    parameter int PHASE_W  = 16,
    parameter int LOG2_AVG = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      clear_i,
    input  logic signed [PHASE_W-1:0] phase_i,
    output logic signed [PHASE_W-1:0] avg_o,
    output logic                      avg_valid_o
);

    localparam int ACC_W = PHASE_W + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_AVG) - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic        [CNT_W-1:0] cnt;

    always_comb begin
        sum = acc + ACC_W'(phase_i);
    end

    // The block's final sample is folded in directly, so the mean is ready the same clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
        end else if (clear_i) begin
            acc         <= '0;
            cnt         <= '0;
            avg_valid_o <= 1'b0;
        end else if (tick) begin
            if (cnt == LAST) begin
                avg_o       <= PHASE_W'(sum >>> LOG2_AVG);
                acc         <= '0;
                cnt         <= '0;
                avg_valid_o <= 1'b1;
            end else begin
                acc         <= sum;
                cnt         <= cnt + CNT_W'(1);
                avg_valid_o <= 1'b0;
            end
        end else begin
            avg_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/loop_filter.sv
// PI loop filter for the PLL: decimated phase error drives a saturating integrator
// and the registered P+I sum becomes the NCO tuning word.
module loop_filter
    import loop_filter_pkg::*;
#(
    parameter int PHASE_W  = DEFAULT_PHASE_W,
    parameter int OUT_W    = DEFAULT_OUT_W,
    parameter int LOG2_AVG = 3,
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 6
) (
    input  logic         clk,
    input  logic         rst,
    loop_filter_if.slave bus
);

    localparam int SUM_W = OUT_W + 2;

    logic signed [PHASE_W-1:0] avg_r;
    logic signed [PHASE_W-1:0] avg_d;
    logic                      v1;
    logic                      v2;
    logic                      isat;
    logic signed [OUT_W-1:0]   integ;
    logic signed [SUM_W-1:0]   isum;
    logic signed [SUM_W-1:0]   osum;
    sat_t                      isat_res;
    sat_t                      osat_res;

    boxcar_decimator #(
        .PHASE_W  (PHASE_W),
        .LOG2_AVG (LOG2_AVG)
    ) u_boxcar (
        .clk         (clk),
        .rst         (rst),
        .tick        (bus.tick),
        .clear_i     (bus.clear_i),
        .phase_i     (bus.phase_i),
        .avg_o       (avg_r),
        .avg_valid_o (v1)
    );

    // Stage 2 adds the proportional path to the integrator value that already includes this block.
    always_comb begin
        isum     = SUM_W'(integ) + SUM_W'(avg_r >>> KI_SHIFT);
        osum     = SUM_W'(integ) + SUM_W'(avg_d >>> KP_SHIFT);
        isat_res = sat_signed(SAT_W'(isum), OUT_W);
        osat_res = sat_signed(SAT_W'(osum), OUT_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ <= '0;
            avg_d <= '0;
            isat  <= 1'b0;
            v2    <= 1'b0;
        end else if (bus.clear_i) begin
            integ <= '0;
            isat  <= 1'b0;
            v2    <= 1'b0;
        end else if (v1) begin
            integ <= OUT_W'(isat_res.value);
            isat  <= isat_res.sat;
            avg_d <= avg_r;
            v2    <= 1'b1;
        end else begin
            v2    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.freq_o  <= '0;
            bus.valid_o <= 1'b0;
            bus.sat_o   <= 1'b0;
        end else if (bus.clear_i) begin
            bus.freq_o  <= '0;
            bus.valid_o <= 1'b0;
            bus.sat_o   <= 1'b0;
        end else if (v2) begin
            bus.freq_o  <= OUT_W'(osat_res.value);
            bus.valid_o <= 1'b1;
            bus.sat_o   <= isat | osat_res.sat;
        end else begin
            bus.valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loop_filter.sv
// Directed bench for loop_filter: scoreboard of expected tuning words checked at their due clock.
module tb_loop_filter;

    typedef struct {
        int   freq;
        logic sat;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m_acc = 0;
    int   m_cnt = 0;
    int   m_integ = 0;
    int   m1_integ = 0;

    loop_filter_if #(.PHASE_W(16), .OUT_W(16)) bus0 ();
    loop_filter_if #(.PHASE_W(16), .OUT_W(16)) bus1 ();

    loop_filter #(
        .PHASE_W(16), .OUT_W(16), .LOG2_AVG(3), .KP_SHIFT(2), .KI_SHIFT(6)
    ) u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    loop_filter #(
        .PHASE_W(16), .OUT_W(16), .LOG2_AVG(0), .KP_SHIFT(2), .KI_SHIFT(6)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int clamp16(input int v, output logic s);
        s = 1'b0;
        if (v > 32767) begin
            s = 1'b1;
            return 32767;
        end
        if (v < -32768) begin
            s = 1'b1;
            return -32768;
        end
        return v;
    endfunction

    function automatic exp_t model_update(input int avg, inout int integ, input int due);
        logic s1;
        logic s2;
        exp_t e;
        integ  = clamp16(integ + (avg >>> 6), s1);
        e.freq = clamp16(integ + (avg >>> 2), s2);
        e.sat  = s1 | s2;
        e.due  = due;
        return e;
    endfunction

    task automatic model_reset0();
        m_acc   = 0;
        m_cnt   = 0;
        m_integ = 0;
        q0.delete();
    endtask

    task automatic apply_stimulus(input int p);
        @(negedge clk);
        bus0.tick    = 1'b1;
        bus0.clear_i = 1'b0;
        bus0.phase_i = 16'(p);
        m_acc += p;
        m_cnt++;
        if (m_cnt == 8) begin
            q0.push_back(model_update(m_acc >>> 3, m_integ, cyc + 3));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle0(input int n);
        repeat (n) begin
            @(negedge clk);
            bus0.tick    = 1'b0;
            bus0.clear_i = 1'b0;
        end
    endtask

    task automatic clear0(input logic with_tick, input int p);
        @(negedge clk);
        bus0.tick    = with_tick;
        bus0.clear_i = 1'b1;
        bus0.phase_i = 16'(p);
        model_reset0();
    endtask

    // Every clock the valid strobe must match whether a result is due; due results are popped and compared.
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        exp_v = (q0.size() != 0) && (q0[0].due == cyc);
        check_output("u0_valid", 32'(bus0.valid_o), 32'(exp_v));
        if (exp_v) begin
            e = q0.pop_front();
            check_output("u0_freq", 32'(bus0.freq_o), 32'(e.freq));
            check_output("u0_sat", 32'(bus0.sat_o), 32'(e.sat));
        end
        exp_v = (q1.size() != 0) && (q1[0].due == cyc);
        check_output("u1_valid", 32'(bus1.valid_o), 32'(exp_v));
        if (exp_v) begin
            e = q1.pop_front();
            check_output("u1_freq", 32'(bus1.freq_o), 32'(e.freq));
            check_output("u1_sat", 32'(bus1.sat_o), 32'(e.sat));
        end
    end

    initial begin
        bus0.tick    = 1'b0;
        bus0.clear_i = 1'b0;
        bus0.phase_i = '0;
        bus1.tick    = 1'b0;
        bus1.clear_i = 1'b0;
        bus1.phase_i = '0;

        #2;
        check_output("reset_freq", 32'(bus0.freq_o), 32'(0));
        check_output("reset_valid", 32'(bus0.valid_o), 32'(0));
        check_output("reset_sat", 32'(bus0.sat_o), 32'(0));
        check_output("reset_u1_freq", 32'(bus1.freq_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        idle0(2);

        // Two blocks of 800: 12+200 then 24+200.
        repeat (8) apply_stimulus(800);
        idle0(4);
        check_output("t1_freq_a", 32'(bus0.freq_o), 32'(212));
        check_output("t1_sat_a", 32'(bus0.sat_o), 32'(0));
        repeat (8) apply_stimulus(800);
        idle0(4);
        check_output("t1_freq_b", 32'(bus0.freq_o), 32'(224));

        // Floor rounding of small negative errors.
        clear0(1'b0, 0);
        idle0(1);
        repeat (8) apply_stimulus(-1);
        idle0(4);
        check_output("t2_freq", 32'(bus0.freq_o), 32'(-2));
        check_output("t2_integ", 32'(u0.integ), 32'(-1));
        check_output("t2_sat", 32'(bus0.sat_o), 32'(0));

        // Positive full-scale drive into output and then integrator saturation.
        clear0(1'b0, 0);
        idle0(1);
        for (int b = 1; b <= 65; b++) begin
            repeat (8) apply_stimulus(32767);
            idle0(4);
            if (b == 48) begin
                check_output("t3_freq_b48", 32'(bus0.freq_o), 32'(32719));
                check_output("t3_sat_b48", 32'(bus0.sat_o), 32'(0));
            end
            if (b == 49) begin
                check_output("t3_freq_b49", 32'(bus0.freq_o), 32'(32767));
                check_output("t3_sat_b49", 32'(bus0.sat_o), 32'(1));
            end
            if (b == 64) check_output("t3_integ_b64", 32'(u0.integ), 32'(32704));
            if (b == 65) begin
                check_output("t3_integ_b65", 32'(u0.integ), 32'(32767));
                check_output("t3_sat_b65", 32'(bus0.sat_o), 32'(1));
            end
        end
        repeat (8) apply_stimulus(-32768);
        idle0(4);
        check_output("t3_antiwindup_integ", 32'(u0.integ), 32'(32255));
        check_output("t3_antiwindup_freq", 32'(bus0.freq_o), 32'(24063));
        check_output("t3_antiwindup_sat", 32'(bus0.sat_o), 32'(0));

        // Clear mid-block discards the partial sum.
        clear0(1'b0, 0);
        idle0(1);
        repeat (5) apply_stimulus(1000);
        clear0(1'b0, 0);
        idle0(1);
        check_output("t4_clear_freq", 32'(bus0.freq_o), 32'(0));
        check_output("t4_clear_valid", 32'(bus0.valid_o), 32'(0));
        repeat (8) apply_stimulus(80);
        idle0(4);
        check_output("t4_freq", 32'(bus0.freq_o), 32'(21));

        // Clear coinciding with the final tick wins and no update appears.
        repeat (7) apply_stimulus(80);
        clear0(1'b1, 80);
        idle0(6);
        check_output("t4_cleartick_freq", 32'(bus0.freq_o), 32'(0));
        check_output("t4_cleartick_integ", 32'(u0.integ), 32'(0));
        repeat (8) apply_stimulus(80);
        idle0(4);
        check_output("t4_after_freq", 32'(bus0.freq_o), 32'(21));

        // No averaging: one update per clock from a ramp, then a wide ramp that moves the integrator.
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            bus1.tick    = 1'b1;
            bus1.phase_i = (i < 16) ? 16'(i) : 16'((i - 16) * 2000 - 30000);
            q1.push_back(model_update((i < 16) ? i : (i - 16) * 2000 - 30000, m1_integ, cyc + 3));
        end
        @(negedge clk);
        bus1.tick = 1'b0;
        idle0(5);
        check_output("t5_drained", 32'(q1.size()), 32'(0));

        // Async reset three ticks into a block.
        repeat (3) apply_stimulus(500);
        idle0(1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset0();
        #1;
        check_output("t6_rst_freq", 32'(bus0.freq_o), 32'(0));
        check_output("t6_rst_valid", 32'(bus0.valid_o), 32'(0));
        check_output("t6_rst_sat", 32'(bus0.sat_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (7) apply_stimulus(500);
        idle0(5);
        check_output("t6_no_early_valid", 32'(bus0.freq_o), 32'(0));
        apply_stimulus(500);
        idle0(4);
        check_output("t6_freq", 32'(bus0.freq_o), 32'(132));
        check_output("t6_drained", 32'(q0.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
